shift_deser_rx: RTL
===================

Name: shift_deser_rx

Overview:
- Downstream consumer of the right-shift register's serial output (its q[0] stream).
- Collects bits LSB-first into DW-bit words, shifting right with each new bit entering at the MSB.
- Presents each completed word on a valid/ready output port, with overflow detection.
- Sits between the shift-register serial link and the word-level datapath.

Parameters:
- DW, 4, data word width in bits (DW >= 2); the bit counter width is derived internally as clog2(DW+1).

Ports:
- clk  input  1  clock, all state on rising edge
- async_rst  input  1  asynchronous reset, active-high
- clr  input  1  synchronous frame abort / flag clear
- bit_in  input  1  serial data bit, LSB of word first
- bit_vld  input  1  bit_in is sampled on this edge when high
- out_rdy  input  1  consumer accepts out_data this cycle
- out_data  output  DW  assembled word
- out_vld  output  1  out_data holds an undelivered word
- busy  output  1  partial word in progress (bit count != 0)
- ovf  output  1  sticky: a completed word was dropped
- par_err  output  1  parity error for the word on out_data (see Optional Feature)

Behaviour:
- Reset (async_rst high, asynchronous):
  - Internal shift register = 0, bit count = 0, state = DATA.
  - out_data = 0, out_vld = 0, ovf = 0, par_err = 0, busy = 0.
- clr (synchronous) has the same effect as reset on all state and outputs. It has priority over bit_vld and out_rdy in the same cycle.
- Shift: on a cycle with bit_vld=1, clr=0:
  - sh <= {bit_in, sh[DW-1:1]}
  - cnt <= cnt+1
- Word completion: a bit_vld cycle with cnt==DW-1 (no parity build) ends the word.
  - cnt returns to 0.
  - The completed word {bit_in, sh[DW-1:1]} is the publish candidate.
- Latency: out_vld rises on the edge after the completing bit is sampled, i.e. out_data is visible in the cycle after that bit is presented.
- Output handshake:
  - Transfer occurs on any edge with out_vld=1 and out_rdy=1.
  - A transfer with no new word clears out_vld; out_data holds its last value.
  - out_vld and out_data are stable while out_rdy=0.
- Completion in the same cycle as a transfer: the new word loads, and out_vld stays 1 (back-to-back, no bubble).
- Completion with out_vld=1 and out_rdy=0:
  - The new word is dropped; out_data keeps the old word.
  - ovf is set and stays 1 until clr or reset.
  - The bit counter still restarts at 0.
- bit_vld=0 holds sh and cnt; gaps between bits are allowed and unbounded.
- busy = (cnt != 0) || (state == PAR); it is combinational from registered state.
- DW=2 edge case: every second bit_vld completes a word.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- Defined:
  - The frame is DW data bits followed by one even-parity bit.
  - FSM: DATA (collect DW bits), then PAR (await one bit_vld), then back to DATA.
  - The DW-th data bit moves the FSM to PAR without publishing.
  - The bit_vld in PAR publishes the word, with par_err = (^word) ^ parity_bit, registered alongside out_data.
  - par_err is meaningful only while out_vld=1 and follows the same load/drop rules as out_data.
  - clr or reset in PAR returns the FSM to DATA.
- Undefined:
  - No PAR state; par_err is tied to 0.
  - The port list is unchanged.

Test Plan:
- DW=4, reset, then bit_vld on 4 consecutive cycles with bit_in 0,1,0,1, out_rdy=1 -> out_vld=1 in the following cycle with out_data=4'hA, for one cycle; busy=1 during bits 2-4, 0 afterwards.
- Word 4'h3 (bits 1,1,0,0) with out_rdy=0, then word 4'h5 (1,0,1,0) -> out_data stays 4'h3, out_vld=1, ovf=1; raise out_rdy -> out_vld=0; ovf remains 1 until clr pulse -> ovf=0.
- Back-to-back: 8 continuous bit_vld forming 4'hC then 4'h6, out_rdy=1 throughout -> out_vld high for both words, with 4'hC then 4'h6 exactly 4 cycles apart; ovf=0.
- Two bits (1,1) sent, then async_rst mid-word, then bits 1,0,0,0 -> busy=0 immediately at reset; resulting out_data=4'h1 (pre-reset bits discarded).
- Bits with random bit_vld gaps (0-5 idle cycles) carrying 4'h9 -> out_data=4'h9; clr asserted together with a bit_vld on bit 3 -> bit dropped, cnt=0, no word published.
- SHIFT_DESER_PARITY_EN: data 4'h7 plus parity 1 -> out_data=4'h7, par_err=0; data 4'h7 plus parity 0 -> par_err=1; out_vld rises only after the 5th bit.

Source files
------------

// File: rtl/shift_deser_rx.sv
// shift_deser_rx: serial-to-word receiver for an LSB-first bit stream.
// Bits enter at the MSB of a right-shifting register; every DW bits form a
// word that is offered on a valid/ready port. A word completing while the
// previous one is still unaccepted is dropped and flagged on sticky ovf.
// Optional feature macro: SHIFT_DESER_PARITY_EN (one even-parity bit after
// the DW data bits, checked result registered on par_err).
module shift_deser_rx #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          clr,
    input  logic          bit_in,
    input  logic          bit_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic          out_vld,
    output logic          busy,
    output logic          ovf,
    output logic          par_err
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic [CW-1:0] cnt;
    logic [DW-1:0] word;
    logic          publish;
    logic          word_pe;

`ifdef SHIFT_DESER_PARITY_EN
    typedef enum logic {DATA, PAR} state_t;
    state_t state;

    // Full DW-bit register: the word waits here while the parity bit arrives.
    logic [DW-1:0] sh;

    // The parity-phase bit publishes the held word and its parity check.
    always_comb begin
        publish = bit_vld && (state == PAR);
        word    = sh;
        word_pe = (^sh) ^ bit_in;
    end

    assign busy = (cnt != '0) || (state == PAR);

    // Collect data bits, then wait one bit for parity before the next frame.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            sh    <= '0;
            cnt   <= '0;
            state <= DATA;
        end else if (clr) begin
            sh    <= '0;
            cnt   <= '0;
            state <= DATA;
        end else if (bit_vld) begin
            if (state == DATA) begin
                sh <= {bit_in, sh[DW-1:1]};
                if (cnt == LAST) begin
                    cnt   <= '0;
                    state <= PAR;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                state <= DATA;
            end
        end
    end
`else
    // Only the newest DW-1 bits are kept; the completing bit is taken live
    // from bit_in, so the register's lowest bit would never be read.
    logic [DW-2:0] sh;

    // The DW-th bit completes the word in the same cycle it is sampled.
    always_comb begin
        publish = bit_vld && (cnt == LAST);
        word    = {bit_in, sh};
        word_pe = 1'b0;
    end

    assign busy = (cnt != '0);

    // Shift in each valid bit and count towards the word boundary.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sh  <= '0;
            cnt <= '0;
        end else if (bit_vld) begin
            sh  <= word[DW-1:1];
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end
`endif

    // Output slot: load a completed word when free or draining, else drop it.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            out_data <= '0;
            out_vld  <= 1'b0;
            ovf      <= 1'b0;
            par_err  <= 1'b0;
        end else if (clr) begin
            out_data <= '0;
            out_vld  <= 1'b0;
            ovf      <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            if (out_vld && out_rdy)
                out_vld <= 1'b0;
            if (publish) begin
                if (!out_vld || out_rdy) begin
                    out_data <= word;
                    par_err  <= word_pe;
                    out_vld  <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule
